// File: rtl/vfpu_stream_ctrl.sv
// vfpu_stream_ctrl
// Job sequencer for the vector FPU streamer. A start pulse latches a job
// descriptor, the streamer is cleared, every source and the sink are started
// in the same cycle, and a done pulse is raised once every stream reports
// completion. A saturating counter measures the REQ..DONE span of each job.
module vfpu_stream_ctrl #(
    parameter int NB_OPERANDS = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int LEN_WIDTH   = 16,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              start_i,
    input  logic [LEN_WIDTH-1:0]              length_i,
    input  logic [NB_OPERANDS*ADDR_WIDTH-1:0] op_addr_i,
    input  logic [ADDR_WIDTH-1:0]             res_addr_i,
    output logic                              busy_o,
    output logic                              done_o,
    output logic                              err_o,
    output logic                              stream_clear_o,
    output logic [NB_OPERANDS-1:0]            src_req_start_o,
    output logic [NB_OPERANDS*ADDR_WIDTH-1:0] src_addr_o,
    output logic [LEN_WIDTH-1:0]              src_trans_size_o,
    input  logic [NB_OPERANDS-1:0]            src_ready_start_i,
    input  logic [NB_OPERANDS-1:0]            src_done_i,
    output logic                              sink_req_start_o,
    output logic [ADDR_WIDTH-1:0]             sink_addr_o,
    output logic [LEN_WIDTH-1:0]              sink_trans_size_o,
    input  logic                              sink_ready_start_i,
    input  logic                              sink_done_i,
    output logic [CNT_WIDTH-1:0]              cycles_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_REQ   = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    state_e                          state_q, state_d;
    logic [LEN_WIDTH-1:0]            len_q, len_d;
    logic [NB_OPERANDS*ADDR_WIDTH-1:0] op_addr_q, op_addr_d;
    logic [ADDR_WIDTH-1:0]           res_addr_q, res_addr_d;
    logic [NB_OPERANDS-1:0]          src_flags_q, src_flags_d;
    logic                            sink_flag_q, sink_flag_d;
    logic [CNT_WIDTH-1:0]            cycles_q, cycles_d;
    logic                            all_ready_s;

    // Increment that sticks at all-ones so very long jobs never wrap to a small count.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] val);
        if (val == {CNT_WIDTH{1'b1}}) begin
            sat_inc = val;
        end else begin
            sat_inc = val + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    endfunction

    assign all_ready_s = (&src_ready_start_i) & sink_ready_start_i;

    // Next-state, descriptor latching, sticky completion flags and cycle counter.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        op_addr_d   = op_addr_q;
        res_addr_d  = res_addr_q;
        src_flags_d = src_flags_q;
        sink_flag_d = sink_flag_q;
        cycles_d    = cycles_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    len_d      = length_i;
                    op_addr_d  = op_addr_i;
                    res_addr_d = res_addr_i;
                    // Zeroed here as well so an empty job, which skips CLEAR, still reports 1.
                    cycles_d   = {CNT_WIDTH{1'b0}};
                    if (length_i == {LEN_WIDTH{1'b0}}) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_CLEAR;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                src_flags_d = {NB_OPERANDS{1'b0}};
                sink_flag_d = 1'b0;
                cycles_d    = {CNT_WIDTH{1'b0}};
                state_d     = ST_REQ;
            end
            ST_REQ: begin
                cycles_d = sat_inc(cycles_q);
                // Start is all-or-nothing: requests leave only when every stream is ready.
                if (all_ready_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_RUN: begin
                cycles_d    = sat_inc(cycles_q);
                src_flags_d = src_flags_q | src_done_i;
                sink_flag_d = sink_flag_q | sink_done_i;
                // Flags set this cycle count, so the last pulse reaches DONE one cycle later.
                if ((&src_flags_d) && sink_flag_d) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                cycles_d = sat_inc(cycles_q);
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, descriptor, flag and counter registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            len_q       <= {LEN_WIDTH{1'b0}};
            op_addr_q   <= {(NB_OPERANDS*ADDR_WIDTH){1'b0}};
            res_addr_q  <= {ADDR_WIDTH{1'b0}};
            src_flags_q <= {NB_OPERANDS{1'b0}};
            sink_flag_q <= 1'b0;
            cycles_q    <= {CNT_WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            op_addr_q   <= op_addr_d;
            res_addr_q  <= res_addr_d;
            src_flags_q <= src_flags_d;
            sink_flag_q <= sink_flag_d;
            cycles_q    <= cycles_d;
        end
    end

    // Output decode from the state register; start requests also qualify on readiness.
    always_comb begin
        busy_o           = (state_q != ST_IDLE);
        done_o           = (state_q == ST_DONE);
        err_o            = start_i & (state_q != ST_IDLE);
        stream_clear_o   = (state_q == ST_CLEAR);
        src_req_start_o  = {NB_OPERANDS{1'b0}};
        sink_req_start_o = 1'b0;
        if ((state_q == ST_REQ) && all_ready_s) begin
            src_req_start_o  = {NB_OPERANDS{1'b1}};
            sink_req_start_o = 1'b1;
        end else begin
            src_req_start_o  = {NB_OPERANDS{1'b0}};
            sink_req_start_o = 1'b0;
        end
    end

    assign src_addr_o        = op_addr_q;
    assign src_trans_size_o  = len_q;
    assign sink_addr_o       = res_addr_q;
    assign sink_trans_size_o = len_q;
    assign cycles_o          = cycles_q;

endmodule

// File: tb/tb_vfpu_stream_ctrl.sv
// Directed self-checking bench for vfpu_stream_ctrl (2 operands).
module tb_vfpu_stream_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [15:0] length_i;
    logic [63:0] op_addr_i;
    logic [31:0] res_addr_i;
    logic        busy_o, done_o, err_o, stream_clear_o;
    logic [1:0]  src_req_start_o;
    logic [63:0] src_addr_o;
    logic [15:0] src_trans_size_o;
    logic [1:0]  src_ready_start_i;
    logic [1:0]  src_done_i;
    logic        sink_req_start_o;
    logic [31:0] sink_addr_o;
    logic [15:0] sink_trans_size_o;
    logic        sink_ready_start_i;
    logic        sink_done_i;
    logic [31:0] cycles_o;

    int n_cmp = 0;
    int n_bad = 0;

    vfpu_stream_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .length_i(length_i),
        .op_addr_i(op_addr_i), .res_addr_i(res_addr_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .stream_clear_o(stream_clear_o),
        .src_req_start_o(src_req_start_o), .src_addr_o(src_addr_o),
        .src_trans_size_o(src_trans_size_o), .src_ready_start_i(src_ready_start_i),
        .src_done_i(src_done_i), .sink_req_start_o(sink_req_start_o),
        .sink_addr_o(sink_addr_o), .sink_trans_size_o(sink_trans_size_o),
        .sink_ready_start_i(sink_ready_start_i), .sink_done_i(sink_done_i),
        .cycles_o(cycles_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one clock; inputs are then driven 2 time units after the edge.
    task automatic cyc();
        @(posedge clk_i);
        #2;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; start_i = 1'b0; length_i = 16'd0; op_addr_i = 64'd0; res_addr_i = 32'd0;
        src_ready_start_i = 2'b11; sink_ready_start_i = 1'b1;
        src_done_i = 2'b00; sink_done_i = 1'b0;
        cyc(); cyc();
        rst_i = 1'b0;
        #1;
        n_cmp++;
        if ({busy_o, done_o, err_o, stream_clear_o, src_req_start_o, sink_req_start_o,
             src_addr_o, sink_addr_o, src_trans_size_o, sink_trans_size_o, cycles_o} !== 167'd0) begin
            n_bad++; $display("FAIL reset_outputs: busy=%b done=%b clr=%b req=%b/%b cyc=%0d, required all zero",
                              busy_o, done_o, stream_clear_o, src_req_start_o, sink_req_start_o, cycles_o);
        end
    endtask

    task automatic test_nominal();
        cyc();
        start_i = 1'b1; length_i = 16'd64; op_addr_i = {32'h2000, 32'h1000}; res_addr_i = 32'h3000;
        #1;
        n_cmp++; if (busy_o !== 1'b0 || stream_clear_o !== 1'b0) begin
            n_bad++; $display("FAIL nom_idle: busy=%b clr=%b, required 0 0", busy_o, stream_clear_o); end
        cyc(); start_i = 1'b0; #1;
        n_cmp++; if (stream_clear_o !== 1'b1 || busy_o !== 1'b1 || src_req_start_o !== 2'b00) begin
            n_bad++; $display("FAIL nom_clear: clr=%b busy=%b req=%b, required 1 1 00",
                              stream_clear_o, busy_o, src_req_start_o); end
        cyc(); #1;
        n_cmp++; if (src_req_start_o !== 2'b11 || sink_req_start_o !== 1'b1 || stream_clear_o !== 1'b0) begin
            n_bad++; $display("FAIL nom_req: req=%b sink=%b clr=%b, required 11 1 0",
                              src_req_start_o, sink_req_start_o, stream_clear_o); end
        n_cmp++; if (src_addr_o !== {32'h2000, 32'h1000} || sink_addr_o !== 32'h3000 ||
                     src_trans_size_o !== 16'd64 || sink_trans_size_o !== 16'd64) begin
            n_bad++; $display("FAIL nom_desc: src=%h sink=%h sz=%0d/%0d, required 0000200000001000 00003000 64/64",
                              src_addr_o, sink_addr_o, src_trans_size_o, sink_trans_size_o); end
        cyc(); #1;  // RUN r1
        n_cmp++; if (src_req_start_o !== 2'b00 || sink_req_start_o !== 1'b0) begin
            n_bad++; $display("FAIL nom_req_once: req=%b sink=%b, required 00 0", src_req_start_o, sink_req_start_o); end
        for (int i = 0; i < 5; i++) cyc();  // r6
        src_done_i = 2'b11;
        cyc(); src_done_i = 2'b00; #1;      // r7
        n_cmp++; if (done_o !== 1'b0 || busy_o !== 1'b1) begin
            n_bad++; $display("FAIL nom_src_only: done=%b busy=%b, required 0 1", done_o, busy_o); end
        for (int i = 0; i < 69; i++) cyc();  // r76
        sink_done_i = 1'b1; #1;
        n_cmp++; if (done_o !== 1'b0) begin
            n_bad++; $display("FAIL nom_done_early: done=%b, required 0", done_o); end
        cyc(); sink_done_i = 1'b0; #1;
        n_cmp++; if (done_o !== 1'b1 || busy_o !== 1'b1) begin
            n_bad++; $display("FAIL nom_done: done=%b busy=%b, required 1 1", done_o, busy_o); end
        cyc(); #1;
        n_cmp++; if (done_o !== 1'b0 || busy_o !== 1'b0 || cycles_o !== 32'd78) begin
            n_bad++; $display("FAIL nom_end: done=%b busy=%b cycles=%0d, required 0 0 78", done_o, busy_o, cycles_o); end
    endtask

    task automatic test_zero_len();
        start_i = 1'b1; length_i = 16'd0; op_addr_i = {32'hB0, 32'hA0}; res_addr_i = 32'hC0;
        #1;
        n_cmp++; if (stream_clear_o !== 1'b0 || src_req_start_o !== 2'b00) begin
            n_bad++; $display("FAIL zl_start: clr=%b req=%b, required 0 00", stream_clear_o, src_req_start_o); end
        cyc(); start_i = 1'b0; #1;
        n_cmp++; if (done_o !== 1'b1 || stream_clear_o !== 1'b0 || src_req_start_o !== 2'b00 ||
                     sink_req_start_o !== 1'b0 || src_trans_size_o !== 16'd0 || sink_addr_o !== 32'hC0) begin
            n_bad++; $display("FAIL zl_done: done=%b clr=%b req=%b/%b sz=%0d sink=%h, required 1 0 00/0 0 c0",
                              done_o, stream_clear_o, src_req_start_o, sink_req_start_o, src_trans_size_o, sink_addr_o); end
        cyc(); #1;
        n_cmp++; if (cycles_o !== 32'd1 || busy_o !== 1'b0 || done_o !== 1'b0) begin
            n_bad++; $display("FAIL zl_end: cycles=%0d busy=%b done=%b, required 1 0 0", cycles_o, busy_o, done_o); end
    endtask

    task automatic test_backpressure();
        sink_ready_start_i = 1'b0;
        start_i = 1'b1; length_i = 16'd4; op_addr_i = {32'h40, 32'h20}; res_addr_i = 32'h60;
        cyc(); start_i = 1'b0;              // CLEAR
        for (int i = 0; i < 5; i++) begin   // REQ q1..q5, sink not ready
            cyc();
            if (i == 1) begin src_done_i = 2'b11; sink_done_i = 1'b1; end
            else begin src_done_i = 2'b00; sink_done_i = 1'b0; end
            #1;
            n_cmp++; if (src_req_start_o !== 2'b00 || sink_req_start_o !== 1'b0) begin
                n_bad++; $display("FAIL bp_hold%0d: req=%b sink=%b, required 00 0", i, src_req_start_o, sink_req_start_o); end
        end
        cyc(); src_done_i = 2'b00; sink_done_i = 1'b0; sink_ready_start_i = 1'b1; #1;  // q6
        n_cmp++; if (src_req_start_o !== 2'b11 || sink_req_start_o !== 1'b1) begin
            n_bad++; $display("FAIL bp_release: req=%b sink=%b, required 11 1", src_req_start_o, sink_req_start_o); end
        cyc(); cyc(); #1;  // r2: pulses seen in REQ must not have completed the job
        n_cmp++; if (done_o !== 1'b0 || busy_o !== 1'b1 || src_req_start_o !== 2'b00) begin
            n_bad++; $display("FAIL bp_outside_run: done=%b busy=%b req=%b, required 0 1 00", done_o, busy_o, src_req_start_o); end
        src_done_i = 2'b11; sink_done_i = 1'b1;  // simultaneous completion
        cyc(); src_done_i = 2'b00; sink_done_i = 1'b0; #1;
        n_cmp++; if (done_o !== 1'b1) begin
            n_bad++; $display("FAIL simul_done: done=%b, required 1", done_o); end
        cyc(); #1;
        n_cmp++; if (cycles_o !== 32'd9 || busy_o !== 1'b0) begin
            n_bad++; $display("FAIL bp_cycles: cycles=%0d busy=%b, required 9 0", cycles_o, busy_o); end
    endtask

    task automatic test_duplicate();
        start_i = 1'b1; length_i = 16'd8; op_addr_i = {32'h400, 32'h300}; res_addr_i = 32'h500;
        cyc(); start_i = 1'b0; cyc(); cyc();  // RUN r1
        src_done_i = 2'b01; cyc(); src_done_i = 2'b00; cyc();
        src_done_i = 2'b01; cyc(); src_done_i = 2'b10; cyc(); src_done_i = 2'b00;
        for (int i = 0; i < 3; i++) cyc();
        #1;
        n_cmp++; if (done_o !== 1'b0 || busy_o !== 1'b1 || stream_clear_o !== 1'b0) begin
            n_bad++; $display("FAIL dup_stay_run: done=%b busy=%b clr=%b, required 0 1 0", done_o, busy_o, stream_clear_o); end
        sink_done_i = 1'b1;
        cyc(); sink_done_i = 1'b0; #1;
        n_cmp++; if (done_o !== 1'b1) begin
            n_bad++; $display("FAIL dup_finish: done=%b, required 1", done_o); end
        cyc();
    endtask

    task automatic test_start_while_busy();
        int dones;
        start_i = 1'b1; length_i = 16'd16; op_addr_i = {32'h20, 32'h10}; res_addr_i = 32'h30;
        cyc(); start_i = 1'b0; cyc(); cyc();  // RUN r1
        start_i = 1'b1; length_i = 16'd99; op_addr_i = {32'hEE, 32'hDD}; res_addr_i = 32'hFF;
        #1;
        n_cmp++; if (err_o !== 1'b1) begin
            n_bad++; $display("FAIL busy_err: err=%b, required 1", err_o); end
        cyc(); start_i = 1'b0; #1;
        n_cmp++; if (err_o !== 1'b0 || src_addr_o !== {32'h20, 32'h10} || sink_addr_o !== 32'h30 ||
                     src_trans_size_o !== 16'd16) begin
            n_bad++; $display("FAIL busy_keep_desc: err=%b src=%h sink=%h sz=%0d, required 0 0000002000000010 00000030 16",
                              err_o, src_addr_o, sink_addr_o, src_trans_size_o); end
        src_done_i = 2'b11; sink_done_i = 1'b1;
        cyc(); src_done_i = 2'b00; sink_done_i = 1'b0;  // DONE
        start_i = 1'b1; #1;
        n_cmp++; if (err_o !== 1'b1 || done_o !== 1'b1) begin
            n_bad++; $display("FAIL done_start_err: err=%b done=%b, required 1 1", err_o, done_o); end
        cyc(); start_i = 1'b0; #1;
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            if (done_o === 1'b1) dones++;
            cyc(); #1;
        end
        n_cmp++; if (busy_o !== 1'b0 || dones !== 0 || src_addr_o !== {32'h20, 32'h10}) begin
            n_bad++; $display("FAIL done_start_reject: busy=%b extra_dones=%0d src=%h, required 0 0 0000002000000010",
                              busy_o, dones, src_addr_o); end
    endtask

    task automatic test_reset_mid_run();
        start_i = 1'b1; length_i = 16'd8; op_addr_i = {32'h88, 32'h77}; res_addr_i = 32'h99;
        cyc(); start_i = 1'b0; cyc(); cyc();  // RUN r1
        src_done_i = 2'b11; cyc(); src_done_i = 2'b00;
        rst_i = 1'b1; cyc(); rst_i = 1'b0; #1;
        n_cmp++;
        if ({busy_o, done_o, err_o, stream_clear_o, src_req_start_o, sink_req_start_o,
             src_addr_o, sink_addr_o, src_trans_size_o, sink_trans_size_o, cycles_o} !== 167'd0) begin
            n_bad++; $display("FAIL rst_mid_outputs: busy=%b src=%h sink=%h sz=%0d cyc=%0d, required all zero",
                              busy_o, src_addr_o, sink_addr_o, src_trans_size_o, cycles_o);
        end
        start_i = 1'b1; length_i = 16'd8; op_addr_i = {32'h1B, 32'h1A}; res_addr_i = 32'h1C;
        cyc(); start_i = 1'b0; #1;
        n_cmp++; if (stream_clear_o !== 1'b1) begin
            n_bad++; $display("FAIL rst_next_clear: clr=%b, required 1", stream_clear_o); end
        cyc(); cyc();  // RUN r1
        sink_done_i = 1'b1; cyc(); sink_done_i = 1'b0; #1;
        n_cmp++; if (done_o !== 1'b0 || busy_o !== 1'b1) begin
            n_bad++; $display("FAIL rst_stale_flags: done=%b busy=%b, required 0 1", done_o, busy_o); end
        src_done_i = 2'b11; cyc(); src_done_i = 2'b00; #1;
        n_cmp++; if (done_o !== 1'b1) begin
            n_bad++; $display("FAIL rst_next_done: done=%b, required 1", done_o); end
        cyc(); #1;
        n_cmp++; if (cycles_o !== 32'd4 || busy_o !== 1'b0) begin
            n_bad++; $display("FAIL rst_next_cycles: cycles=%0d busy=%b, required 4 0", cycles_o, busy_o); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_zero_len();
        test_backpressure();
        test_duplicate();
        test_start_while_busy();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
